// File: rtl/gray_seq_checker.sv
// Gray-coded stream checker: converts each valid sample to binary, verifies +1 (mod 2^N)
// stepping, acquires lock after LOCK_CNT good steps and counts step errors while locked.
module gray_seq_checker #(
  parameter int unsigned N        = 3,
  parameter int unsigned LOCK_CNT = 4,
  parameter int unsigned CW       = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [N:1]    gray_in,
  input  logic          valid_in,
  input  logic          err_clr,
  output logic [N:1]    bin_out,
  output logic          bin_valid,
  output logic          locked,
  output logic          step_err,
  output logic [CW-1:0] err_count
);

  localparam int unsigned GcW = $clog2(LOCK_CNT + 1);

  typedef enum logic [1:0] {StIdle, StAcq, StLocked} state_e;

  state_e          state_q, state_d;
  logic [GcW-1:0]  good_cnt_q, good_cnt_d;
  logic [N:1]      bin_out_q, bin_out_d;
  logic            bin_valid_q, bin_valid_d;
  logic            step_err_q, step_err_d;
  logic [CW-1:0]   err_count_q, err_count_d;

  logic [N:1]      bin;
  logic [GcW-1:0]  good_inc;
  logic            good_step;
  logic            err_inc;

  always_comb begin
    bin    = '0;
    bin[N] = gray_in[N];
    for (int i = N - 1; i >= 1; i--) begin
      bin[i] = bin[i+1] ^ gray_in[i];
    end
  end

  // bin_out_q doubles as the previous-sample register: both load b on every valid sample.
  assign good_step = (bin == bin_out_q + N'(1));
  assign good_inc  = good_cnt_q + GcW'(1);

  always_comb begin
    state_d     = state_q;
    good_cnt_d  = good_cnt_q;
    bin_out_d   = bin_out_q;
    bin_valid_d = 1'b0;
    step_err_d  = 1'b0;
    err_inc     = 1'b0;

    if (valid_in) begin
      bin_out_d   = bin;
      bin_valid_d = 1'b1;
      unique case (state_q)
        StIdle: begin
          state_d    = StAcq;
          good_cnt_d = '0;
        end
        StAcq: begin
          if (!good_step) begin
            good_cnt_d = '0;
          end else if (good_inc == GcW'(LOCK_CNT)) begin
            state_d    = StLocked;
            good_cnt_d = '0;
          end else begin
            good_cnt_d = good_inc;
          end
        end
        StLocked: begin
          if (!good_step) begin
            step_err_d = 1'b1;
            err_inc    = 1'b1;
            state_d    = StAcq;
            good_cnt_d = '0;
          end
        end
        default: begin
          state_d    = StIdle;
          good_cnt_d = '0;
        end
      endcase
    end
  end

  // Clear takes priority over a coincident error; saturate instead of wrapping.
  always_comb begin
    err_count_d = err_count_q;
    if (err_clr) begin
      err_count_d = '0;
    end else if (err_inc && (err_count_q != {CW{1'b1}})) begin
      err_count_d = err_count_q + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      good_cnt_q  <= '0;
      bin_out_q   <= '0;
      bin_valid_q <= 1'b0;
      step_err_q  <= 1'b0;
      err_count_q <= '0;
    end else begin
      state_q     <= state_d;
      good_cnt_q  <= good_cnt_d;
      bin_out_q   <= bin_out_d;
      bin_valid_q <= bin_valid_d;
      step_err_q  <= step_err_d;
      err_count_q <= err_count_d;
    end
  end

  assign bin_out   = bin_out_q;
  assign bin_valid = bin_valid_q;
  assign locked    = (state_q == StLocked);
  assign step_err  = step_err_q;
  assign err_count = err_count_q;

endmodule

// File: tb/tb_gray_seq_checker.sv
// Directed plus randomized bench for gray_seq_checker, checked against an integer-level
// model of the stepping/lock/error rules.
module tb_gray_seq_checker;

  localparam int unsigned N        = 3;
  localparam int unsigned LOCK_CNT = 4;
  localparam int unsigned CW       = 8;
  localparam int          Mod      = 1 << N;
  localparam int          Sat      = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [N:1]    gray_in;
  logic          valid_in;
  logic          err_clr;
  logic [N:1]    bin_out;
  logic          bin_valid;
  logic          locked;
  logic          step_err;
  logic [CW-1:0] err_count;

  int tests = 0;
  int fails = 0;

  // Reference model state
  int m_bin, m_run, m_err, m_bv, m_se;
  bit m_have, m_lock;
  int cur;

  gray_seq_checker #(.N(N), .LOCK_CNT(LOCK_CNT), .CW(CW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .gray_in   (gray_in),
    .valid_in  (valid_in),
    .err_clr   (err_clr),
    .bin_out   (bin_out),
    .bin_valid (bin_valid),
    .locked    (locked),
    .step_err  (step_err),
    .err_count (err_count)
  );

  always #5 clk = ~clk;

  function automatic int gray2bin(input int g);
    int b = 0;
    for (int i = 0; i < N; i++) b ^= (g >> i);
    return b % Mod;
  endfunction

  function automatic int bin2gray(input int b);
    return (b ^ (b >> 1)) % Mod;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_bin = 0; m_run = 0; m_err = 0; m_bv = 0; m_se = 0;
    m_have = 0; m_lock = 0;
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".bin_out"},   32'(bin_out),   m_bin);
    chk({tag, ".bin_valid"}, 32'(bin_valid), m_bv);
    chk({tag, ".step_err"},  32'(step_err),  m_se);
    chk({tag, ".locked"},    32'(locked),    32'(m_lock));
    chk({tag, ".err_count"}, 32'(err_count), m_err);
  endtask

  // Apply one cycle of inputs, advance the model, and check after the edge.
  task automatic step(input string tag, input bit v, input int g, input bit clr);
    bit good, einc;
    int b;
    valid_in = v;
    gray_in  = N'(g);
    err_clr  = clr;
    einc = 0;
    m_bv = v;
    m_se = 0;
    if (v) begin
      b = gray2bin(g);
      if (!m_have) begin
        m_have = 1;
        m_run  = 0;
      end else begin
        good = (b == (m_bin + 1) % Mod);
        if (m_lock) begin
          if (!good) begin
            m_se = 1; einc = 1; m_lock = 0; m_run = 0;
          end
        end else if (good) begin
          m_run++;
          if (m_run == LOCK_CNT) begin
            m_lock = 1; m_run = 0;
          end
        end else begin
          m_run = 0;
        end
      end
      m_bin = b;
      cur   = b;
    end
    if (clr) m_err = 0;
    else if (einc && m_err < Sat) m_err++;
    @(posedge clk);
    #1;
    check_all(tag);
    valid_in = 0;
    err_clr  = 0;
  endtask

  task automatic send(input string tag, input int b);
    step(tag, 1'b1, bin2gray(b), 1'b0);
  endtask

  task automatic send_next(input string tag);
    send(tag, (cur + 1) % Mod);
  endtask

  initial begin
    int r;
    rst_n    = 1'b0;
    valid_in = 1'b0;
    gray_in  = '0;
    err_clr  = 1'b0;
    cur      = 0;
    model_reset();
    #12;
    check_all("reset");
    rst_n = 1'b1;

    // 1: full gray sweep from IDLE; lock arrives with bin_out=4
    for (int i = 0; i < Mod; i++) begin
      send("sweep", i);
      if (i == 4) chk("lock_at_4", 32'(locked), 1);
      if (i == 3) chk("not_lock_at_3", 32'(locked), 0);
    end

    // 2: wrap 7 -> 0 -> 1 while locked
    send("wrap0", 0);
    send("wrap1", 1);
    chk("wrap_locked", 32'(locked), 1);

    // 3: skip from 2 to 4, then relock after 4 good steps
    send("pre_skip", 2);
    send("skip", 4);
    chk("skip_err", 32'(step_err), 1);
    chk("skip_cnt", 32'(err_count), 1);
    for (int i = 0; i < 4; i++) send_next("relock");
    chk("relocked", 32'(locked), 1);

    // 4: repeated value while locked
    send("rep_a", (cur + 1) % Mod);
    send("rep_b", cur);
    chk("rep_cnt", 32'(err_count), 2);
    step("rep_quiet", 1'b0, 0, 1'b0);
    for (int i = 0; i < 4; i++) send_next("relock2");

    // 5: idle gap while locked
    for (int i = 0; i < 5; i++) step("gap", 1'b0, $urandom_range(0, Mod - 1), 1'b0);
    send_next("resume");
    chk("gap_locked", 32'(locked), 1);

    // 6: third error, relock, then err_clr coincident with a fourth error
    send("err3", (cur + 3) % Mod);
    chk("err3_cnt", 32'(err_count), 3);
    for (int i = 0; i < 4; i++) send_next("relock3");
    step("clr_vs_err", 1'b1, bin2gray((cur + 2) % Mod), 1'b1);
    chk("clr_wins", 32'(err_count), 0);

    // Asynchronous reset mid-cycle while locked
    for (int i = 0; i < 5; i++) send_next("lock4");
    #3 rst_n = 1'b0;
    #1;
    model_reset();
    check_all("async_rst");
    #2 rst_n = 1'b1;
    send("post_rst_first", 5);
    chk("post_rst_noerr", 32'(step_err), 0);

    // Saturation: many locked errors
    for (int i = 0; i < 5; i++) send_next("sat_lock");
    for (int k = 0; k < Sat + 5; k++) begin
      send("sat_bad", (cur + 2) % Mod);
      for (int i = 0; i < 4; i++) send_next("sat_relock");
    end
    chk("sat_value", 32'(err_count), Sat);
    step("sat_clr", 1'b0, 0, 1'b1);

    // Randomized mix against the model
    for (int k = 0; k < 600; k++) begin
      r = $urandom_range(0, 99);
      if (r < 65)      step("rnd_next", 1'b1, bin2gray((cur + 1) % Mod), ($urandom_range(0, 19) == 0));
      else if (r < 80) step("rnd_gap",  1'b0, $urandom_range(0, Mod - 1), ($urandom_range(0, 19) == 0));
      else if (r < 92) step("rnd_any",  1'b1, $urandom_range(0, Mod - 1), ($urandom_range(0, 19) == 0));
      else             step("rnd_rep",  1'b1, bin2gray(cur), 1'b0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/gray_seq_checker.md
Name: gray_seq_checker

Overview:
- Receive-side companion to the n-bit Gray code generator.
- Samples an N-bit Gray-coded stream, converts each sample to binary, and checks that consecutive samples advance by exactly +1 (mod 2^N).
- Acquires lock after a run of correct steps, flags step errors while locked, and keeps a saturating error count.
- Sits downstream of n_bit_gen, in its testbench or on a link monitor.

Parameters:
- N, 3: Gray/binary word width. Ports are packed [N:1], matching the generator's out bus.
- LOCK_CNT, 4: consecutive correct steps needed to enter LOCKED. Must be ≥1.
- CW, 8: width of err_count.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous, active-low reset.
- gray_in  input  [N:1]  Gray-coded sample.
- valid_in  input  1  gray_in is sampled on any clk edge where valid_in=1.
- err_clr  input  1  synchronous clear of err_count.
- bin_out  output  [N:1]  binary equivalent of the last valid sample (registered).
- bin_valid  output  1  one-cycle pulse; bin_out was updated this cycle.
- locked  output  1  high while the FSM is in LOCKED.
- step_err  output  1  one-cycle pulse; a step error occurred while LOCKED.
- err_count  output  [CW-1:0]  saturating count of step errors.

Behaviour:
- Reset (rst_n=0, asynchronous):
  - bin_out=0, bin_valid=0, locked=0, step_err=0, err_count=0.
  - FSM goes to IDLE; prev register=0; good_cnt=0.
  - Reset applies immediately, mid-stream included. Nothing is retained.
- Conversion (combinational):
  - b[N] = g[N]
  - b[i] = b[i+1] ^ g[i] for i = N-1 down to 1.
- Latency: a sample taken at edge k appears on bin_out/bin_valid after edge k, i.e. one cycle. step_err and locked update on the same edge as the sample's bin_valid.
- valid_in=0 cycles:
  - No state change.
  - bin_valid=0, step_err=0.
  - bin_out, locked, err_count hold.
  - Gaps of any length are not errors.
- "Good step": b == prev+1 mod 2^N. Wrap from 2^N-1 to 0 is good. A repeated value, a skip, or a backwards step is bad.
- prev is loaded with b on every valid sample, in all states.
- FSM, evaluated only on valid samples:
  - IDLE: capture the first sample with no comparison. Go to ACQ, good_cnt=0.
  - ACQ, good step: good_cnt++. When good_cnt reaches LOCK_CNT, go to LOCKED and clear good_cnt.
  - ACQ, bad step: good_cnt=0, stay in ACQ. No step_err and no count change.
  - LOCKED, good step: stay in LOCKED.
  - LOCKED, bad step: pulse step_err, increment err_count, go to ACQ with good_cnt=0. locked deasserts on the same edge as the step_err pulse.
- err_count:
  - Saturates at 2^CW-1; no wrap.
  - err_clr=1 forces it to 0 on the next edge. If err_clr and an error coincide, clear wins and the result is 0.
  - err_clr does not affect the FSM or any other output.
- No combinational path from inputs to outputs; all outputs are registered.

Test Plan (N=3, LOCK_CNT=4, CW=8):
1. Reset, then feed continuous valid gray 000,001,011,010,110,111,101,100 → bin_out follows 0..7, one cycle late. bin_valid is high every cycle. locked rises with the bin_out=4 update (1 capture + 4 good steps). step_err stays 0.
2. Continue from locked with 100 → 000 → 001 → bin_out 7→0→1. No step_err; locked stays 1.
3. Locked at bin 2 (gray 011), feed 110 (bin 4, a skip) → step_err pulses for one cycle, err_count=1, locked=0. The next 4 good steps re-lock.
4. Locked, feed 010 twice (repeated value) → one step_err pulse, err_count increments by 1.
5. Locked, insert 5 idle cycles (valid_in=0) mid-sequence, then resume the correct next code → bin_valid=0 during the gap, locked stays 1, no error.
6. With err_count=3, assert err_clr in the same cycle as a step error → err_count=0. Separately, pull rst_n low asynchronously mid-cycle while locked → all outputs are 0 immediately. After release, the first sample is captured in IDLE with no error.
